// File: rtl/axil_wb_pkg.sv
// Shared types and constants for the AXI-Lite slave to Wishbone master bridge.
package axil_wb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_WR  = 3'd1,
        WB_RD  = 3'd2,
        B_RESP = 3'd3,
        R_RESP = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

endpackage

// File: rtl/axil_wb_watchdog.sv
// Ack-wait counter for the bridge; expired_o pulses on the TIMEOUT-th cycle of a
// Wishbone cycle that has not been acknowledged.
module axil_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axil_wb_master.sv
// AXI-Lite slave to classic Wishbone master bridge, one transaction in flight.
// Define AXIL_WB_TIMEOUT_EN to abort unacknowledged cycles with SLVERR.
module axil_wb_master
    import axil_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    state_e            state_q, state_d;
    logic              rst_done_q, rst_done_d;
    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              ar_full_q, ar_full_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;

    logic aw_hs, w_hs, ar_hs;
    logic wr_req, rd_req;
    logic in_wb;
    logic wd_expired;

    // Readies stay low until the first edge after reset release.
    assign awready = rst_done_q && !aw_full_q;
    assign wready  = rst_done_q && !w_full_q;
    assign arready = rst_done_q && !ar_full_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign ar_hs = arvalid && arready;

    // A handshake in the current cycle counts, so a grant can happen the same edge.
    assign wr_req = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign rd_req = ar_full_q || ar_hs;

    assign in_wb     = (state_q == WB_WR) || (state_q == WB_RD);
    assign wbm_cyc_o = in_wb;
    assign wbm_stb_o = in_wb;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

    assign bvalid = (state_q == B_RESP);
    assign rvalid = (state_q == R_RESP);
    assign bresp  = bresp_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

`ifdef AXIL_WB_TIMEOUT_EN
    axil_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (axis_clk),
        .rst_ni    (axis_rst_n),
        .clear_i   (state_q == IDLE),
        .en_i      (in_wb),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rst_done_d   = 1'b1;
        aw_full_d    = aw_full_q;
        aw_addr_d    = aw_addr_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        ar_full_d    = ar_full_q;
        ar_addr_d    = ar_addr_q;
        last_grant_d = last_grant_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        bresp_d      = bresp_q;
        rresp_d      = rresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_addr_d = araddr;
        end

        case (state_q)
            IDLE: begin
                // last_grant only moves on a real tie: 1 means the write won it.
                if (wr_req && (!rd_req || !last_grant_q)) begin
                    state_d = WB_WR;
                    adr_d   = aw_full_q ? aw_addr_q : awaddr;
                    dat_d   = w_full_q ? w_data_q : wdata;
                    sel_d   = w_full_q ? w_strb_q : wstrb;
                    we_d    = 1'b1;
                    if (rd_req) begin
                        last_grant_d = 1'b1;
                    end
                end else if (rd_req) begin
                    state_d = WB_RD;
                    adr_d   = ar_full_q ? ar_addr_q : araddr;
                    sel_d   = 4'hF;
                    we_d    = 1'b0;
                    if (wr_req) begin
                        last_grant_d = 1'b0;
                    end
                end
            end
            WB_WR: begin
                if (wbm_ack_i) begin
                    state_d = B_RESP;
                    bresp_d = RESP_OKAY;
                    we_d    = 1'b0;
                end else if (wd_expired) begin
                    state_d = B_RESP;
                    bresp_d = RESP_SLVERR;
                    we_d    = 1'b0;
                end
            end
            WB_RD: begin
                if (wbm_ack_i) begin
                    state_d = R_RESP;
                    rdata_d = wbm_dat_i;
                    rresp_d = RESP_OKAY;
                end else if (wd_expired) begin
                    state_d = R_RESP;
                    rdata_d = DATA_W'(ERR_DATA);
                    rresp_d = RESP_SLVERR;
                end
            end
            B_RESP: begin
                if (bready) begin
                    state_d   = IDLE;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            R_RESP: begin
                if (rready) begin
                    state_d   = IDLE;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q      <= IDLE;
            rst_done_q   <= 1'b0;
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ar_full_q    <= 1'b0;
            ar_addr_q    <= '0;
            last_grant_q <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            bresp_q      <= RESP_OKAY;
            rresp_q      <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            rst_done_q   <= rst_done_d;
            aw_full_q    <= aw_full_d;
            aw_addr_q    <= aw_addr_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            ar_full_q    <= ar_full_d;
            ar_addr_q    <= ar_addr_d;
            last_grant_q <= last_grant_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
        end
    end

endmodule

// File: doc/axil_wb_master.md
# axil_wb_master

AXI-Lite slave to Wishbone master bridge: accepts single-beat AXI-Lite reads and writes from a DMA engine or accelerator, and replays each as one classic Wishbone cycle toward the user-area arbiter or memory. It is the reverse of the Wishbone-to-AXI bridge in the user project wrapper. Requests are strictly serialized, one outstanding transaction at a time. Reads and writes are round-robin arbitrated when both are pending.

## Interface
- ADDR_W, 32, AXI/Wishbone address width (passed through unchanged)
- DATA_W, 32, data width; must be 32 (4 byte lanes)
- TIMEOUT, 255, max cycles waiting for wbm_ack_i (used only with AXIL_WB_TIMEOUT_EN)

Ports:
- axis_clk  in  1  single clock
- axis_rst_n  in  1  reset, asynchronous, active-low
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  ADDR_W  write address
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  DATA_W  write data
- wstrb  in  4  byte strobes → wbm_sel_o
- bvalid / bready  out / in  1  write-response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  ADDR_W  read address
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  DATA_W  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_dat_i  in  DATA_W  read data
- wbm_ack_i  in  1  cycle acknowledge

## Operation
- States: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
- IDLE behaviour:
  - awready, wready and arready are asserted whenever the matching holding register is empty.
  - AW and W are captured independently, in either order or in the same cycle.
  - The ready for a channel drops once that channel's value is held.
- Grant rules:
  - A write is complete when both AW and W are held. A read is complete when AR is held.
  - If only one request is complete, it is granted.
  - If both are complete, grant goes to the opposite of the `last_grant` bit. `last_grant` is 0 after reset, so a write wins the first tie.
- WB_WR / WB_RD:
  - cyc and stb are held high; adr, sel, dat and we are stable from the held registers.
  - For reads, sel is 4'hF.
  - wbm_ack_i is honoured only while stb is high.
  - On ack, read data is latched into rdata, cyc/stb drop, and the FSM moves to B_RESP or R_RESP.
- B_RESP / R_RESP:
  - bvalid/rvalid is held until bready/rready.
  - The holding registers are cleared on that handshake, and the FSM returns to IDLE.
  - A new AR may be accepted during B_RESP, and AW/W during R_RESP. None is granted until IDLE.
- Responses are OKAY unless a timeout occurs (see Configuration).

## Timing
- Reset values: every valid, ready, cyc, stb and we is 0; bresp, rresp, rdata, wbm_adr_o, wbm_dat_o and wbm_sel_o are 0. Reset is asynchronous and takes effect immediately.
- awready, wready and arready first rise on the first axis_clk edge after reset release.
- Read latency:
  - AR handshake in cycle 0; cyc/stb high from cycle 1.
  - Ack sampled in cycle k; cyc/stb low and rvalid high in cycle k+1.
- Write latency: the last of AW/W handshakes in cycle 0, then the same sequence as a read, with bvalid in place of rvalid.
- Zero-wait slave (ack in cycle 1): rvalid/bvalid in cycle 2.
- Back-to-back: a pending request starts its Wishbone cycle one cycle after the response handshake. cyc is never high in two adjacent transactions without a low cycle between them.
- Reset mid-cycle: cyc/stb drop asynchronously and all held requests are discarded. The slave must tolerate the abandoned cycle.

## Configuration
- Macro AXIL_WB_TIMEOUT_EN.
- Defined:
  - A counter is cleared when cyc rises and increments while it waits for ack.
  - When the counter reaches TIMEOUT with no ack, cyc/stb drop and the response is SLVERR with rdata = 32'hDEADBEEF.
  - An ack arriving in the same cycle as the timeout wins, giving an OKAY response.
- Undefined: no counter; the bridge waits for ack indefinitely and the response is always OKAY.

## Structure
- Package axil_wb_pkg holds: the state enum; RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; ERR_DATA=32'hDEADBEEF.
- One sub-module, axil_wb_watchdog: the timeout counter, with clear/enable/expired ports. It is instantiated only under AXIL_WB_TIMEOUT_EN.

## Test plan
- Write in isolation: AW 0x3800_0010 and W 0xA5A5_0001 with wstrb 4'hF, slave acks after 3 cycles → adr 0x3800_0010, dat 0xA5A5_0001, sel F, we=1; bvalid 4 cycles after handshake; bresp 00.
- Write with W before AW: W first, AW 2 cycles later, wstrb 4'h3 → single Wishbone cycle with sel 4'h3; wready low while waiting for AW.
- Read: AR 0x3000_0004, slave returns 0x1234_5678 → rdata 0x1234_5678, rresp 00; rvalid held through 3 cycles of rready=0.
- Tie arbitration: write and read both complete in the same cycle, twice → order write, read, read, write, with one idle cyc cycle between transactions.
- Timeout, with the macro defined and TIMEOUT=8: slave never acks a read → SLVERR with rdata 0xDEADBEEF after 8 cycles. Without the macro: cyc stays high for 100+ cycles.
- Reset asserted in WB_RD → cyc, stb and rvalid are 0 immediately; after release, arready=1 and no stale response appears.
